// File: rtl/sdram_frame_fetcher_if.sv
// Request bus toward the single-word SDRAM read controller
// and the valid/ready pixel stream toward the display pipeline.
interface sdram_frame_fetcher_if;
  logic [24:0] mem_address;
  logic        mem_read_enable;
  logic [15:0] mem_data_in;
  logic        mem_read_done;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output mem_address,
    output mem_read_enable,
    input  mem_data_in,
    input  mem_read_done,
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  mem_address,
    input  mem_read_enable,
    output mem_data_in,
    output mem_read_done,
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/sdram_frame_fetcher.sv
// Walks a frame-buffer region one SDRAM word at a time, one request
// in flight, and buffers returned words in a small FWFT FIFO.
module sdram_frame_fetcher #(
  parameter logic [24:0] BASE_ADDR   = 25'd0,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned FIFO_DEPTH  = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic [LW-1:0] fifo_level,
  sdram_frame_fetcher_if.master bus
);

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [24:0]   WORDS_L = 25'(FRAME_WORDS);
  localparam logic [24:0]   LAST_L  = 25'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_THROTTLE,
    S_REQ,
    S_WAIT,
    S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [24:0]   idx_q, idx_d;
  logic [24:0]   addr_q, addr_d;
  logic          rden_q, rden_d;
  logic          busy_q, busy_d;
  logic          fdone_q, fdone_d;
  logic          rd_done_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic done_rise;
  logic push;
  logic pop;
  logic valid;

  // read_done is a level; only its rising edge marks returned data
  assign done_rise = bus.mem_read_done & ~rd_done_q;
  assign valid     = (cnt_q != '0);
  assign pop       = valid & bus.pix_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          state_d = S_THROTTLE;
        end
      end
      S_THROTTLE: begin
        if (!bus.mem_read_done &&
            cnt_q < DEPTH_L &&
            idx_q < WORDS_L)
          state_d = S_REQ;
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (done_rise) begin
          push    = 1'b1;
          idx_d   = idx_q + 25'd1;
          addr_d  = BASE_ADDR + idx_q + 25'd1;
          state_d = (idx_q == LAST_L) ?
                    S_FINISH : S_THROTTLE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    rden_d  = (state_d == S_REQ);
    fdone_d = (state_d == S_FINISH);
    busy_d  = (state_d == S_THROTTLE) ||
              (state_d == S_REQ) ||
              (state_d == S_WAIT);
    cnt_d   = cnt_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      rden_q    <= 1'b0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      rden_q    <= rden_d;
      busy_q    <= busy_d;
      fdone_q   <= fdone_d;
      rd_done_q <= bus.mem_read_done;
      cnt_q     <= cnt_d;
      if (push)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= bus.mem_data_in;
  end

  assign bus.mem_address     = addr_q;
  assign bus.mem_read_enable = rden_q;
  assign bus.pix_valid       = valid;
  // head word is masked while empty so stale data never leaks out
  assign bus.pix_data        = valid ? mem_q[rptr_q] : 16'h0;
  assign busy                = busy_q;
  assign frame_done          = fdone_q;
  assign fifo_level          = cnt_q;

endmodule

// File: tb/tb_sdram_frame_fetcher.sv
// Bench for sdram_frame_fetcher: behavioural SDRAM controller,
// random consumer, queue-based expected address/pixel sequences.
module tb_sdram_frame_fetcher;
  localparam logic [24:0] BASE = 25'h1FFFFFE;
  localparam int FW    = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_level;

  sdram_frame_fetcher_if mif();

  sdram_frame_fetcher #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .frame_done(frame_done),
    .fifo_level(fifo_level),
    .bus       (mif.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int en_viol  = 0;
  int hold_cyc = 2;
  logic [24:0] issued[$];
  logic [15:0] got[$];
  logic rand_rdy = 1'b0;
  logic rdy_fix  = 1'b0;
  logic rnd_bit  = 1'b0;
  logic prev_en  = 1'b0;

  assign mif.pix_ready = rand_rdy ? rnd_bit : rdy_fix;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Controller model: data = address, done held hold_cyc cycles
  initial begin : ctrl_model
    logic [24:0] ra;
    int lat;
    bit abort;
    mif.mem_read_done = 1'b0;
    mif.mem_data_in   = 16'h0;
    forever begin
      @(negedge clk);
      if (reset || !mif.mem_read_enable) continue;
      ra = mif.mem_address;
      issued.push_back(ra);
      lat = $urandom_range(1, 3);
      abort = 1'b0;
      for (int c = 0; c < lat; c++) begin
        @(posedge clk);
        if (reset) abort = 1'b1;
      end
      #1;
      if (!abort && !reset) begin
        mif.mem_data_in   = ra[15:0];
        mif.mem_read_done = 1'b1;
        for (int c = 0; c < hold_cyc; c++) begin
          @(posedge clk);
          if (reset) break;
        end
        #1;
        mif.mem_read_done = 1'b0;
        mif.mem_data_in   = 16'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) begin
        done_cnt++;
        if (busy) en_viol++;
      end
      if (mif.mem_read_enable &&
          (mif.mem_read_done || prev_en))
        en_viol++;
      if (mif.pix_valid && mif.pix_ready)
        got.push_back(mif.pix_data);
    end
    prev_en = mif.mem_read_enable;
  end

  task automatic pulse_start(string tag);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_t"}, 32'(busy), 1);
    chk({tag, "_en_t"}, 32'(mif.mem_read_enable), 0);
    chk({tag, "_addr_t"}, 32'(mif.mem_address), 32'(BASE));
    @(negedge clk);
    chk({tag, "_en_t1"}, 32'(mif.mem_read_enable), 1);
    chk({tag, "_addr_t1"}, 32'(mif.mem_address), 32'(BASE));
  endtask

  task automatic wait_done(int target, string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_to"}, 32'(done_cnt >= target), 1);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (mif.pix_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_drained"}, 32'(mif.pix_valid), 0);
    chk({tag, "_level0"}, 32'(fifo_level), 0);
  endtask

  task automatic check_frame(string tag, int i0, int g0);
    logic [31:0] ea;
    logic [31:0] oa;
    logic [31:0] op;
    chk({tag, "_nreq"}, 32'(issued.size() - i0), FW);
    chk({tag, "_npix"}, 32'(got.size() - g0), FW);
    for (int i = 0; i < FW; i++) begin
      ea = (32'(BASE) + 32'(i)) & 32'h01FF_FFFF;
      oa = (i0 + i < issued.size()) ?
           32'(issued[i0 + i]) : 32'hDEAD_BEEF;
      op = (g0 + i < got.size()) ?
           32'(got[g0 + i]) : 32'hDEAD_BEEF;
      chk({tag, "_addr"}, oa, ea);
      chk({tag, "_pix"}, op, {16'h0, ea[15:0]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int i0;
    int g0;
    int n;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_addr", 32'(mif.mem_address), 0);
    chk("rst_en", 32'(mif.mem_read_enable), 0);
    chk("rst_valid", 32'(mif.pix_valid), 0);
    chk("rst_data", 32'(mif.pix_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // basic frame with wrap across the top of the address space
    hold_cyc = 2;
    rdy_fix  = 1'b1;
    i0 = issued.size();
    g0 = got.size();
    pulse_start("basic");
    wait_done(1, "basic");
    @(negedge clk);
    chk("basic_busy_after", 32'(busy), 0);
    drain("basic");
    check_frame("basic", i0, g0);
    chk("basic_ndone", 32'(done_cnt), 1);

    // backpressure: fetch stalls on a full FIFO
    rdy_fix = 1'b0;
    i0 = issued.size();
    g0 = got.size();
    pulse_start("bp");
    n = 0;
    while (fifo_level != 3'(DEPTH) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    chk("bp_level", 32'(fifo_level), DEPTH);
    chk("bp_nreq", 32'(issued.size() - i0), DEPTH);
    chk("bp_en", 32'(mif.mem_read_enable), 0);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_head", 32'(mif.pix_data), 32'(BASE[15:0]));
    rand_rdy = 1'b1;
    wait_done(2, "bp");
    drain("bp");
    rand_rdy = 1'b0;
    rdy_fix  = 1'b1;
    check_frame("bp", i0, g0);

    // long read_done level, random consumer
    hold_cyc = 5;
    rand_rdy = 1'b1;
    i0 = issued.size();
    g0 = got.size();
    pulse_start("long");
    wait_done(3, "long");
    drain("long");
    rand_rdy = 1'b0;
    check_frame("long", i0, g0);
    chk("long_en_viol", 32'(en_viol), 0);

    // start while busy and start during the finish cycle are dropped
    hold_cyc = 2;
    i0 = issued.size();
    g0 = got.size();
    pulse_start("sb");
    n = 0;
    while (issued.size() - i0 < 3 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!frame_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sb_fdone_seen", 32'(frame_done), 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(negedge clk);
    chk("sb_ndone", 32'(done_cnt), 4);
    chk("sb_busy", 32'(busy), 0);
    drain("sb");
    check_frame("sb", i0, g0);

    // reset in WAIT of word 2, then a fresh frame from BASE
    rdy_fix = 1'b0;
    i0 = issued.size();
    pulse_start("rm");
    n = 0;
    while (issued.size() - i0 < 3 && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rm_reached", 32'(issued.size() - i0), 3);
    reset = 1'b1;
    #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_fdone", 32'(frame_done), 0);
    chk("rm_addr", 32'(mif.mem_address), 0);
    chk("rm_en", 32'(mif.mem_read_enable), 0);
    chk("rm_valid", 32'(mif.pix_valid), 0);
    chk("rm_data", 32'(mif.pix_data), 0);
    chk("rm_level", 32'(fifo_level), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rm_ndone", 32'(done_cnt), 4);
    rdy_fix = 1'b1;
    i0 = issued.size();
    g0 = got.size();
    pulse_start("rs");
    wait_done(5, "rs");
    drain("rs");
    check_frame("rs", i0, g0);
    chk("final_en_viol", 32'(en_viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
